// File: rtl/write_back.sv
// MEM/WB pipeline register and register-file write port driver for the MIPS core.
// Optional retire counter is compiled in with `define WB_RETIRE_COUNT_EN.
module write_back #(
   parameter int len = 32,
   parameter int NB  = $clog2(len)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            in_valid,
   input  logic [1:0]      in_writeBack_bus,
   input  logic [2:0]      in_mem_type,
   input  logic [1:0]      in_byte_offset,
   input  logic [len-1:0]  in_read_data,
   input  logic [len-1:0]  in_alu_result,
   input  logic            in_link,
   input  logic [len-1:0]  in_pc_link,
   input  logic [NB-1:0]   in_write_register,
   input  logic            in_count_clear,
   output logic            RegWrite,
   output logic [len-1:0]  write_data,
   output logic [NB-1:0]   write_register,
   output logic [31:0]     out_retired
);

   typedef enum logic [2:0] {
      MT_LW  = 3'b000,
      MT_LH  = 3'b001,
      MT_LHU = 3'b010,
      MT_LB  = 3'b011,
      MT_LBU = 3'b100
   } mem_type_t;

   logic [15:0]    half_sel;
   logic [7:0]     byte_sel;
   logic [len-1:0] load_data;
   logic [len-1:0] sel_data;
   logic           reg_write_next;
   logic           capture;

   assign capture = ~stall;

   // Little-endian lane selection; offset[0] is ignored for halfwords.
   always_comb begin
      half_sel = in_byte_offset[1] ? in_read_data[31:16] : in_read_data[15:0];
      unique case (in_byte_offset)
         2'd0:    byte_sel = in_read_data[7:0];
         2'd1:    byte_sel = in_read_data[15:8];
         2'd2:    byte_sel = in_read_data[23:16];
         default: byte_sel = in_read_data[31:24];
      endcase
   end

   always_comb begin
      load_data = in_read_data;
      case (in_mem_type)
         MT_LH:   load_data = {{(len-16){half_sel[15]}}, half_sel};
         MT_LHU:  load_data = {{(len-16){1'b0}}, half_sel};
         MT_LB:   load_data = {{(len-8){byte_sel[7]}}, byte_sel};
         MT_LBU:  load_data = {{(len-8){1'b0}}, byte_sel};
         default: load_data = in_read_data;
      endcase
   end

   always_comb begin
      if (in_link)
         sel_data = in_pc_link;
      else if (in_writeBack_bus[0])
         sel_data = load_data;
      else
         sel_data = in_alu_result;
      reg_write_next = in_valid & in_writeBack_bus[1] & (in_write_register != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         RegWrite       <= 1'b0;
         write_data     <= '0;
         write_register <= '0;
      end else if (capture) begin
         RegWrite       <= reg_write_next;
         write_data     <= sel_data;
         write_register <= in_write_register;
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retired;

   // Clear is checked before stall so the debug unit can zero a frozen pipe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         retired <= '0;
      else if (in_count_clear)
         retired <= '0;
      else if (capture && in_valid)
         retired <= retired + 32'd1;
   end

   assign out_retired = retired;
`else
   logic unused_clear;
   assign unused_clear = in_count_clear;
   assign out_retired  = '0;
`endif

endmodule

// File: doc/write_back.md
# write_back

Final MIPS pipeline stage, writer side of the decode stage's register-file write port. Captures the memory-stage result into the MEM/WB pipeline register, selects ALU result, extracted load data or link address, and drives `RegWrite`/`write_data`/`write_register` into decode one cycle later. Also suppresses writes to `$0`, honours the debug-unit stall, and optionally counts retired instructions for the debug unit.

## Interface
Parameters:
- `len`, 32, datapath width
- `NB`, `$clog2(len)`, register-index width

Ports:
- `clk`  in  1  system clock, rising-edge
- `reset`  in  1  asynchronous, active-low reset
- `stall`  in  1  debug-unit hold; 1 freezes all state
- `in_valid`  in  1  memory-stage result valid this cycle
- `in_writeBack_bus`  in  2  [1]=RegWrite, [0]=MemtoReg (same encoding decode emits)
- `in_mem_type`  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101-111 treated as LW
- `in_byte_offset`  in  2  load address bits [1:0]
- `in_read_data`  in  len  data-memory word
- `in_alu_result`  in  len  execute result
- `in_link`  in  1  JAL/JALR: write link address
- `in_pc_link`  in  len  return address for link
- `in_write_register`  in  NB  destination index (already 31 for JAL)
- `in_count_clear`  in  1  synchronous clear of retire counter
- `RegWrite`  out  1  register-file write enable to decode
- `write_data`  out  len  register-file write data
- `write_register`  out  NB  register-file write index
- `out_retired`  out  32  retired-instruction count

## Operation
- Capture condition: rising `clk`, `reset`=1, `stall`=0.
- On capture: `RegWrite` <= `in_valid` & `in_writeBack_bus[1]` & (`in_write_register` != 0); `write_register` <= `in_write_register`; `write_data` <= selected value.
- Data select priority: `in_link` -> `in_pc_link`; else `in_writeBack_bus[0]` -> extracted load; else `in_alu_result`.
- Load extraction, little-endian lanes (byte n = bits [8n+7:8n]):
  - LW: full word; `in_byte_offset` ignored.
  - LH/LHU: halfword `in_byte_offset[1]` (0 -> [15:0], 1 -> [31:16]); offset[0] ignored; LH sign-extends bit 15 of the halfword, LHU zero-extends.
  - LB/LBU: byte `in_byte_offset`; LB sign-extends, LBU zero-extends.
- `in_valid`=0 on capture: bubble; `RegWrite` <= 0, `write_data`/`write_register` still updated (don't-care).
- Write to `$0`: `RegWrite` forced 0 regardless of control bits.
- Stall: all registers hold; a held `RegWrite`=1 rewrites the same data/index, which is idempotent and permitted.
- Retire counter (when compiled in): increments by 1 on each capture with `in_valid`=1; wraps 0xFFFFFFFF -> 0; `in_count_clear`=1 sets it to 0 (clear wins over increment, honoured even during stall).

## Timing
- Latency: 1 cycle from input presentation to `RegWrite`/`write_data`/`write_register`.
- Throughput: one result per cycle when `stall`=0.
- Reset (`reset`=0, asynchronous assert, synchronous release on next edge): `RegWrite`=0, `write_data`=0, `write_register`=0, `out_retired`=0.
- Reset mid-stall or mid-stream: in-flight result discarded; first post-reset capture is a fresh instruction.
- Outputs driven from registers only; no combinational path input -> output.

## Configuration
- Macro `WB_RETIRE_COUNT_EN`.
- Defined: 32-bit retire counter implemented as above, `out_retired` driven from it.
- Undefined: no counter flops; `out_retired` tied to 0; `in_count_clear` ignored. All other behaviour identical.

## Test plan
- Reset: hold `reset`=0 with arbitrary inputs -> all outputs 0; release, present ALU op `in_alu_result`=0x12345678, rd=5, bus=2'b10 -> next cycle `RegWrite`=1, `write_register`=5, `write_data`=0x12345678.
- Loads: `in_read_data`=0x80FF7F01, MemtoReg=1; LB offset 3 -> 0xFFFFFF80; LBU offset 3 -> 0x00000080; LH offset 2 -> 0xFFFF80FF; LHU offset 0 -> 0x00007F01; LW offset 1 -> 0x80FF7F01.
- Link and `$0`: `in_link`=1, `in_pc_link`=0x00000048, rd=31, MemtoReg=1 -> `write_data`=0x48, `write_register`=31; ALU write to rd=0 -> `RegWrite`=0.
- Stall/bubble: capture value A, assert `stall` 3 cycles while changing inputs -> outputs stay A; `in_valid`=0 capture -> `RegWrite`=0.
- Counter (macro defined): 10 valid captures, 2 bubbles, 3 stalled cycles -> `out_retired`=10; preload to 0xFFFFFFFF then one valid capture -> 0; `in_count_clear`=1 with valid capture -> 0. Macro undefined -> `out_retired`=0 throughout.
